fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_if.sv | 17 +
 rtl/fifo_rd_skid.sv | 61 ++++++
 rtl/fifo_rd_ctrl.sv | 118 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO read controller slice.
// The optional statistics feature is enabled by defining FIFO_RD_CTRL_STATS_EN.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/fifo_if.sv
// FIFO read port bundle: the controller is the master, the FIFO is the slave.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  // rd pops one word when empty=0; that word appears on dout one cycle later
  // and stays there until the next accepted rd. rd must never be high while empty=1.
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              empty;

  modport master (output rd, input dout, input empty);
  modport slave  (input rd, output dout, output empty);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read data and the output stream.
// Head entry drives the output; a push while full is never issued by the controller.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] head_q, tail_q;
  logic [1:0]        cnt_q;
  logic              pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? head_q : '0;
  assign occupancy = cnt_q;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= in_data;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_q <= in_data;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop keeps the count; the new word lands behind the survivor.
          if (cnt_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pulls burst_len words from a FIFO and streams them out.
// Define FIFO_RD_CTRL_STATS_EN to add the word_cnt/stall_cnt statistics outputs.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  fifo_if.master            fifo,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
`ifdef FIFO_RD_CTRL_STATS_EN
  output logic [15:0]       word_cnt,
  output logic [15:0]       stall_cnt,
`endif
  output rd_state_e         dbg_state
);

  localparam int CNT_W = LEN_W + 1;

  rd_state_e         state, state_nxt;
  logic [CNT_W-1:0]  issue_cnt, deliv_cnt, len_ext;
  logic              inflight, rd_int, done_int, xfer;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        occ, room_used;

  assign len_ext   = (burst_len == '0) ? (CNT_W'(1) << LEN_W) : {1'b0, burst_len};
  assign xfer      = m_valid && m_ready;
  // Slots committed for the next edge: what survives this cycle's pop plus the word in flight.
  assign room_used = occ - {1'b0, xfer} + {1'b0, inflight};

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (fifo.dout),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .out_ready (m_ready),
    .occupancy (occ)
  );

  always_comb begin
    state_nxt = state;
    rd_int    = 1'b0;
    done_int  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_READ;
      end
      ST_READ: begin
        if (issue_cnt == '0) begin
          state_nxt = ST_DRAIN;
        end else if (!fifo.empty && (room_used < 2'd2)) begin
          rd_int = 1'b1;
          if (issue_cnt == CNT_W'(1)) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (deliv_cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_int  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      deliv_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_int;
      if (state == ST_IDLE && start) begin
        issue_cnt <= len_ext;
        deliv_cnt <= len_ext;
      end else begin
        if (rd_int && issue_cnt != '0) issue_cnt <= issue_cnt - CNT_W'(1);
        if (xfer && deliv_cnt != '0)   deliv_cnt <= deliv_cnt - CNT_W'(1);
      end
    end
  end

  // Outputs are forced quiet while rst is high so the reset cycle itself shows idle values.
  assign fifo.rd   = rd_int && !rst;
  assign m_valid   = skid_valid && !rst;
  assign m_data    = rst ? '0 : skid_data;
  assign busy      = (state != ST_IDLE) && !rst;
  assign done      = done_int && !rst;
  assign dbg_state = state;

`ifdef FIFO_RD_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (xfer) word_cnt <= word_cnt + 16'd1;
      if (state == ST_READ && fifo.empty && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO on fifo_if, scoreboard fed by a burst-level model.
// Define FIFO_RD_CTRL_STATS_EN to also exercise the statistics outputs.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              busy, done;
  rd_state_e         dbg_state;
`ifdef FIFO_RD_CTRL_STATS_EN
  logic [15:0]       word_cnt, stall_cnt;
`endif
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;

  fifo_if #(.DATA_W(DATA_W)) fi ();

  fifo_rd_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .fifo      (fi),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
`ifdef FIFO_RD_CTRL_STATS_EN
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural FIFO (slave side of fifo_if) ----------------
  logic [DATA_W-1:0] fifo_q[$];
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fi.dout  <= '0;
      fi.empty <= 1'b1;
    end else begin
      if (fi.rd && fifo_q.size() != 0) fi.dout <= fifo_q.pop_front();
      if (wr_en) fifo_q.push_back(wr_data);
      fi.empty <= (fifo_q.size() == 0);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // A burst of L claims the next L words written to the FIFO, in write order.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mdl_q[$];
  int owed = 0;
  int exp_done = 0;
  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  int xfer_cnt = 0;
  int rd_cnt = 0;
  int xfer_cyc[$];
  int lo = -1;
  int hi = -1;
  bit ready_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void settle();
    while (owed > 0 && mdl_q.size() > 0) begin
      exp_q.push_back(mdl_q.pop_front());
      owed--;
    end
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    bit                prev_stall = 1'b0;
    bit                prev_done  = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        rd_cnt     = xfer_cnt;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (fi.rd) begin
          rd_cnt++;
          chk("rd_while_empty", 32'(fi.empty), 32'd0);
        end
        if (m_valid && m_ready) begin
          xfer_cnt++;
          xfer_cyc.push_back(cyc);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL data_unexpected: got 0x%0h expected no transfer (cycle %0d)", m_data, cyc);
          end else begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            if (m_data !== e) begin
              n_fail++;
              $display("FAIL data: got 0x%0h expected 0x%0h (cycle %0d)", m_data, e, cyc);
            end
          end
        end
        if (fi.rd) chk("outstanding_le2", 32'((rd_cnt - xfer_cnt) <= 2), 32'd1);
        if (done) begin
          done_seen++;
          chk("done_one_cycle", 32'(prev_done), 32'd0);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_done  = done;
      end
    end
  end

  // ---------------- m_ready driver ----------------
  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= lo && cyc <= hi) m_ready = 1'b0;
      else if (ready_rand)        m_ready = 1'($urandom_range(0, 1));
      else                        m_ready = 1'b1;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic write_words(input int n, input bit incr, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] d;
      d = incr ? base + DATA_W'(i) : DATA_W'($urandom);
      wr_en   = 1'b1;
      wr_data = d;
      mdl_q.push_back(d);
      settle();
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic noise_cycle();
    if (busy && $urandom_range(0, 3) == 0) begin
      start     = 1'b1;
      burst_len = LEN_W'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic write_gapped(input int n, input int gmin, input int gmax,
                              input bit incr, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(gmin, gmax);
      repeat (g) noise_cycle();
      write_words(1, incr, base + DATA_W'(i));
    end
  endtask

  task automatic start_burst(input logic [LEN_W-1:0] len);
    start     = 1'b1;
    burst_len = len;
    if (!busy) begin
      owed += (len == '0) ? (1 << LEN_W) : int'(len);
      exp_done++;
      settle();
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    burst_len = LEN_W'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    int base;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", 32'(fi.rd), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("post_rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_RD_CTRL_STATS_EN
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;

`ifdef FIFO_RD_CTRL_STATS_EN
    // two bursts of 5; the second waits three READ cycles on an empty FIFO
    write_words(5, 1'b0, '0);
    start_burst(LEN_W'(5));
    wait_idle("stats_b1_idle");
    start_burst(LEN_W'(5));
    repeat (2) begin @(posedge clk); #1; end
    write_words(5, 1'b0, '0);
    wait_idle("stats_b2_idle");
    chk("stats_word_cnt", 32'(word_cnt), 32'd10);
    chk("stats_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("stats_done", done_seen, exp_done);
`endif

    // preloaded 0x01..0x04 at full throughput
    write_words(4, 1'b1, 8'h01);
    xfer_cyc.delete();
    base = xfer_cnt;
    start_burst(LEN_W'(4));
    wait_idle("basic_idle");
    chk("basic_count", xfer_cnt - base, 4);
    if (xfer_cyc.size() == 4)
      for (int i = 0; i < 3; i++) chk("basic_back_to_back", xfer_cyc[i+1] - xfer_cyc[i], 1);
    chk("basic_done", done_seen, exp_done);
    chk("basic_busy_after", 32'(busy), 32'd0);

    // start on an empty FIFO, words trickle in at 10-cycle gaps
    base = xfer_cnt;
    start_burst(LEN_W'(3));
    write_gapped(3, 10, 10, 1'b1, 8'hA0);
    wait_idle("trickle_idle");
    chk("trickle_count", xfer_cnt - base, 3);
    chk("trickle_done", done_seen, exp_done);

    // downstream stall for cycles 2..7 of the burst
    write_words(4, 1'b1, 8'h10);
    base = xfer_cnt;
    lo = cyc + 2;
    hi = cyc + 7;
    start_burst(LEN_W'(4));
    wait_idle("stall_idle");
    lo = -1;
    hi = -1;
    chk("stall_count", xfer_cnt - base, 4);
    chk("stall_done", done_seen, exp_done);

    // reset after the second transfer of a 6-word burst
    write_words(6, 1'b1, 8'h30);
    base = xfer_cnt;
    start_burst(LEN_W'(6));
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (xfer_cnt >= base + 2) begin
          seen = 1'b1;
          break;
        end
      end
      chk("abort_reach_2nd", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    mdl_q.delete();
    owed = 0;
    exp_done--;
    @(negedge clk);
    chk("abort_rst_m_valid", 32'(m_valid), 32'd0);
    chk("abort_rst_rd", 32'(fi.rd), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", done_seen, exp_done);
    @(posedge clk);
    #1;
    write_words(3, 1'b1, 8'h50);
    base = xfer_cnt;
    start_burst(LEN_W'(3));
    wait_idle("after_abort_idle");
    chk("after_abort_count", xfer_cnt - base, 3);
    chk("after_abort_done", done_seen, exp_done);

    // burst_len 0 means 16 words; 4 of 20 must remain
    write_words(20, 1'b0, '0);
    base = xfer_cnt;
    start_burst(LEN_W'(0));
    wait_idle("len0_idle");
    chk("len0_count", xfer_cnt - base, 16);
    chk("len0_fifo_left", fifo_q.size(), 4);
    chk("len0_empty", 32'(fi.empty), 32'd0);
    chk("len0_done", done_seen, exp_done);

    // randomized bursts with random backpressure and ignored start pulses
    ready_rand = 1'b1;
    for (int b = 0; b < 6; b++) begin
      logic [LEN_W-1:0] len;
      int               words;
      len   = LEN_W'($urandom_range(0, 15));
      words = (len == '0) ? 16 : int'(len);
      base  = xfer_cnt;
      start_burst(len);
      write_gapped(words, 0, 3, 1'b0, '0);
      wait_idle("rand_idle");
      chk("rand_count", xfer_cnt - base, words);
      chk("rand_done", done_seen, exp_done);
    end
    ready_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
